aes_128_shift_mix_addkey: RTL and testbench
===========================================

Name: aes_128_shift_mix_addkey

Overview:
- Round-datapath stage directly downstream of aes_128_subbytes.
- Takes the SubBytes result, applies ShiftRows, then MixColumns (skipped on round 10), then XORs the round key.
- Two-stage register pipeline with valid tracking.
- Internal round counter: detects the final round and flags block completion to the round controller.

Parameters:
- NR, 10, rounds per block (AES-128); the counter range is 1..NR.
- KEY_W, 128, state and round-key width; fixed for AES-128 and not intended to be overridden.

Ports:
- clk  input  1  rising-edge clock
- kill  input  1  asynchronous active-high reset
- in_valid  input  1  in_data/round_key are valid this cycle
- in_start  input  1  qualifies in_valid: this beat is round 1 of a new block
- in_data  input  128  SubBytes output state; byte 0 at [127:120], column-major (byte 4c+r = row r, column c)
- round_key  input  128  round key for this beat, same byte order
- out_valid  output  1  out_data valid
- out_data  output  128  ShiftRows/MixColumns/AddRoundKey result
- out_round  output  4  round number (1..NR) of the out_data beat
- out_last  output  1  out_data is the final round (block result)
- err  output  1  one-cycle pulse: beat dropped (in_valid without in_start while idle)

Behaviour:
- Reset: kill is asynchronous and active-high, with one clock, clk.
  - While kill is high, all outputs are 0 and the pipeline valids are 0.
  - While kill is high, the round counter is 0 (idle).
- Round counter rnd[3:0]:
  - in_valid & in_start: rnd_beat = 1 (restarts even mid-block).
  - in_valid & !in_start & rnd != 0: rnd_beat = rnd + 1.
  - in_valid & !in_start & rnd == 0: beat dropped; err = 1 for one cycle, 2 cycles later (aligned with the out_* slot); no out_valid.
  - After the beat is accepted: rnd <= (rnd_beat == NR) ? 0 : rnd_beat. The counter returns to idle after round NR.
- Stage 1, registered on the in_valid cycle:
  - ShiftRows: s'(r,c) = s(r,(c+r) mod 4).
  - MixColumns over GF(2^8), poly 0x11B. Per column:
    - o0 = 2a0^3a1^a2^a3
    - o1 = a0^2a1^3a2^a3
    - o2 = a0^a1^2a2^3a3
    - o3 = 3a0^a1^a2^2a3
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
  - When rnd_beat == NR, MixColumns is bypassed.
  - round_key, rnd_beat and last are captured alongside the data.
- Stage 2, registered: out_data = stage1_data ^ stage1_key; out_round and out_last are forwarded.
- Latency: exactly 2 clocks from the in_valid edge to out_valid.
- Throughput: 1 beat/clock, no backpressure; back-to-back beats are legal.
- out_valid is a one-cycle pulse per accepted beat. Data registers update only on valid, and otherwise hold.
- out_last = 1 only when out_round == NR.
- kill asserted mid-block: the pipeline is flushed and the counter goes to idle. The next beat needs in_start.

Decomposition:
- Package aes_128_pkg:
  - NR and the GF polynomial constant 8'h1B
  - xtime function
  - mix_column function (32 -> 32)
  - shift_rows function (128 -> 128)
- One sub-module, aes_128_mixcolumns: combinational, 128 -> 128, four mix_column instances.
  - It is reused later by the inverse-cipher team.

Test Plan:
- Reset: assert kill for 50 ns mid-operation -> all outputs 0 immediately; the next beat without in_start raises err two clocks later.
- FIPS-197 App. B round 1:
  - Drive in_start=1, in_data=128'hd42711aee0bf98f1b8b45de51e415230, round_key=128'ha0fafe1788542cb123a339392a6c7605.
  - Expect, 2 clocks later: out_data=128'ha49c7ff2689f352b6b5bea43026a5049, out_round=1, out_last=0.
- Final round:
  - Drive 9 back-to-back beats from in_start. The 10th beat carries in_data=128'he9098972cb31075f3d327d94af2e2cb5 and round_key=128'hd014f9a8c9ee2589e13f0cc8b6630ca6.
  - Expect out_data=128'h3925841d02dc09fbdc118597196a0b32, out_round=10, out_last=1, counter idle.
- MixColumns identity: in_data=128'h01010101_01010101_01010101_01010101, round_key=0, round 1 -> out_data=128'h01010101_01010101_01010101_01010101.
- Restart: at round 5, drive in_start=1 -> that beat's out_round=1; round 10 is reached only after 9 further beats.
- Idle drop: in_valid=1, in_start=0 after reset -> err pulses once at +2 clocks, out_valid stays 0, no out_data change.

Source files
------------

// File: rtl/aes_128_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the round datapath.
package aes_128_pkg;
  localparam int NR = 10;
  localparam int KEY_W = 128;
  localparam logic [7:0] GF_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Column word holds row 0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    o0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    o1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    o2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    o3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {o0, o1, o2, o3};
  endfunction

  // Byte 4c+r (row r, column c) sits at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/aes_128_mixcolumns.sv
// Combinational MixColumns over the full 128-bit state, one mixer per column.
module aes_128_mixcolumns
  import aes_128_pkg::*;
(
  input  logic [KEY_W-1:0] state_in,
  output logic [KEY_W-1:0] state_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign state_out[127-32*c -: 32] = mix_column(state_in[127-32*c -: 32]);
  end
endmodule

// File: rtl/aes_128_shift_mix_addkey.sv
// ShiftRows -> MixColumns (bypassed on the final round) -> AddRoundKey,
// two register stages, with the per-block round counter.
module aes_128_shift_mix_addkey
  import aes_128_pkg::*;
(
  input  logic             clk,
  input  logic             kill,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic [KEY_W-1:0] in_data,
  input  logic [KEY_W-1:0] round_key,
  output logic             out_valid,
  output logic [KEY_W-1:0] out_data,
  output logic [3:0]       out_round,
  output logic             out_last,
  output logic             err
);
  // Handshake: valid-only, no ready. A beat transfers on every clock where
  // in_valid is high; out_valid pulses for one clock per accepted beat.
  localparam logic [3:0] NR4 = 4'(NR);

  logic [3:0]       rnd_q, rnd_d, rnd_beat;
  logic             accept, drop, last_beat;
  logic [KEY_W-1:0] shifted, mixed;

  logic             s1_valid_q, s1_valid_d, s1_err_q, s1_err_d, s1_last_q, s1_last_d;
  logic [3:0]       s1_round_q, s1_round_d;
  logic [KEY_W-1:0] s1_data_q, s1_data_d, s1_key_q, s1_key_d;

  logic             out_valid_q, out_valid_d, err_q, err_d, out_last_q, out_last_d;
  logic [3:0]       out_round_q, out_round_d;
  logic [KEY_W-1:0] out_data_q, out_data_d;

  assign shifted = shift_rows(in_data);

  aes_128_mixcolumns u_mix (
    .state_in  (shifted),
    .state_out (mixed)
  );

  always_comb begin
    rnd_beat    = 4'd0;
    accept      = 1'b0;
    drop        = 1'b0;
    rnd_d       = rnd_q;
    if (in_valid) begin
      if (in_start) begin
        rnd_beat = 4'd1;
        accept   = 1'b1;
      end else if (rnd_q != 4'd0) begin
        rnd_beat = rnd_q + 4'd1;
        accept   = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    last_beat = accept && (rnd_beat == NR4);
    if (accept) rnd_d = last_beat ? 4'd0 : rnd_beat;

    s1_valid_d = accept;
    s1_err_d   = drop;
    s1_data_d  = s1_data_q;
    s1_key_d   = s1_key_q;
    s1_round_d = s1_round_q;
    s1_last_d  = s1_last_q;
    if (accept) begin
      s1_data_d  = last_beat ? shifted : mixed;
      s1_key_d   = round_key;
      s1_round_d = rnd_beat;
      s1_last_d  = last_beat;
    end

    out_valid_d = s1_valid_q;
    err_d       = s1_err_q;
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
    if (s1_valid_q) begin
      out_data_d  = s1_data_q ^ s1_key_q;
      out_round_d = s1_round_q;
      out_last_d  = s1_last_q;
    end
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      rnd_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_key_q    <= '0;
      s1_round_q  <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      rnd_q       <= rnd_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      s1_data_q   <= s1_data_d;
      s1_key_q    <= s1_key_d;
      s1_round_q  <= s1_round_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_round_q <= out_round_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_round = out_round_q;
  assign out_last  = out_last_q;
  assign err       = err_q;
endmodule

// File: tb/tb_aes_128_shift_mix_addkey.sv
// Directed bench for aes_128_shift_mix_addkey using FIPS-197 App. B vectors.
module tb_aes_128_shift_mix_addkey;
  localparam logic [127:0] V_D1  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V_O1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] V_D10 = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] V_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] V_O10 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V_ONE = 128'h01010101_01010101_01010101_01010101;

  typedef struct packed {
    logic [31:0]  due;
    logic         last;
    logic [3:0]   rnd;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         kill;
  logic         in_valid, in_start;
  logic [127:0] in_data, round_key;
  logic         out_valid, out_last, err;
  logic [127:0] out_data;
  logic [3:0]   out_round;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] last_exp_data = '0;

  aes_128_shift_mix_addkey dut (
    .clk       (clk),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .in_data   (in_data),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_round (out_round),
    .out_last  (out_last),
    .err       (err)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input logic start, input logic [127:0] d, input logic [127:0] k,
                            input logic [127:0] exp_data, input logic [3:0] exp_rnd);
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    in_start  = start;
    in_data   = d;
    round_key = k;
    e.due  = 32'(cyc + 2);
    e.last = (exp_rnd == 4'd10);
    e.rnd  = exp_rnd;
    e.data = exp_data;
    exp_q.push_back(e);
    last_exp_data = exp_data;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    repeat (4) @(negedge clk);
    #1;
    check_eq(tag, 128'(exp_q.size()), 128'd0);
  endtask

  // A beat without in_start while idle is dropped and flagged two clocks later.
  task automatic idle_drop(input string tag);
    @(negedge clk);
    in_valid  = 1'b1;
    in_start  = 1'b0;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    round_key = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b0;
    check_eq({tag, "_err_early"}, 128'(err), 128'd0);
    @(negedge clk);
    check_eq({tag, "_err"}, 128'(err), 128'd1);
    check_eq({tag, "_no_valid"}, 128'(out_valid), 128'd0);
    check_eq({tag, "_data_hold"}, out_data, last_exp_data);
    @(negedge clk);
    check_eq({tag, "_err_pulse"}, 128'(err), 128'd0);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (!kill && out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 128'(out_valid), 128'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("latency", 128'(cyc), 128'(e.due));
        check_eq("data", out_data, e.data);
        check_eq("round", 128'(out_round), 128'(e.rnd));
        check_eq("last", 128'(out_last), 128'(e.last));
      end
    end
  end

  initial begin
    kill      = 1'b1;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    in_data   = '0;
    round_key = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 128'(out_valid), 128'd0);
    check_eq("rst_data", out_data, 128'd0);
    check_eq("rst_round", 128'(out_round), 128'd0);
    check_eq("rst_last", 128'(out_last), 128'd0);
    check_eq("rst_err", 128'(err), 128'd0);
    kill = 1'b0;

    idle_drop("drop_after_reset");

    drive_beat(1'b1, V_D1, V_K1, V_O1, 4'd1);
    idle_cycle();
    wait_drain("drain_fips_r1");

    drive_beat(1'b1, V_ONE, 128'd0, V_ONE, 4'd1);
    idle_cycle();
    wait_drain("drain_identity");

    drive_beat(1'b1, V_D1, V_K1, V_O1, 4'd1);
    for (int i = 2; i <= 9; i++) drive_beat(1'b0, V_D1, V_K1, V_O1, 4'(i));
    drive_beat(1'b0, V_D10, V_K10, V_O10, 4'd10);
    idle_cycle();
    wait_drain("drain_final");
    idle_drop("drop_after_final");

    drive_beat(1'b1, V_D1, V_K1, V_O1, 4'd1);
    for (int i = 2; i <= 4; i++) drive_beat(1'b0, V_D1, V_K1, V_O1, 4'(i));
    drive_beat(1'b1, V_D1, V_K1, V_O1, 4'd1);
    for (int i = 2; i <= 9; i++) drive_beat(1'b0, V_D1, V_K1, V_O1, 4'(i));
    drive_beat(1'b0, V_D10, V_K10, V_O10, 4'd10);
    idle_cycle();
    wait_drain("drain_restart");
    idle_drop("drop_after_restart");

    drive_beat(1'b1, V_D1, V_K1, V_O1, 4'd1);
    drive_beat(1'b0, V_D1, V_K1, V_O1, 4'd2);
    drive_beat(1'b0, V_D1, V_K1, V_O1, 4'd3);
    #2;
    kill = 1'b1;
    #1;
    check_eq("kill_valid", 128'(out_valid), 128'd0);
    check_eq("kill_data", out_data, 128'd0);
    check_eq("kill_round", 128'(out_round), 128'd0);
    check_eq("kill_last", 128'(out_last), 128'd0);
    check_eq("kill_err", 128'(err), 128'd0);
    exp_q.delete();
    last_exp_data = '0;
    in_valid = 1'b0;
    in_start = 1'b0;
    #50;
    @(negedge clk);
    kill = 1'b0;
    idle_drop("drop_after_kill");
    wait_drain("drain_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
